// File: rtl/multdiv_ctrl.sv
// Signed 32-bit multiply (radix-2 Booth) / divide (restoring on magnitudes) sharing one adder_32.
// Latency 33 cycles (mul) / 36 cycles (div); no backpressure, a new start aborts any operation in flight.

module adder_32 (
    output logic [31:0] S,
    output logic        O,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin
);
    assign S = A + B + {31'b0, Cin};
    assign O = (A[31] == B[31]) && (S[31] != A[31]);
endmodule

module multdiv_ctrl #(
    parameter int ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    typedef enum logic [2:0] {
        IDLE, MUL_ITER, DIV_ABSA, DIV_ABSB, DIV_ITER, DIV_SIGN, DONE
    } state_t;

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     acc_q, lo_q, b_q, result_q;
    logic            qm1_q, mul_q, neg_q, exc_q, rdy_q;

    logic            start;
    logic [31:0]     add_x, add_y, add_s, rem_sh;
    logic            add_cin, add_o_unused, add_cout, add_ext;
    logic            booth_add, booth_sub;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign booth_sub = lo_q[0] & ~qm1_q;
    assign booth_add = ~lo_q[0] & qm1_q;
    assign rem_sh    = {acc_q[30:0], lo_q[31]};

    adder_32 u_add (
        .S   (add_s),
        .O   (add_o_unused),
        .A   (add_x),
        .B   (add_y),
        .Cin (add_cin)
    );

    // Carry out and true 33-bit sign recovered from the MSBs, so no wider adder is needed.
    assign add_cout = (add_x[31] & add_y[31]) | ((add_x[31] | add_y[31]) & ~add_s[31]);
    assign add_ext  = add_x[31] ^ add_y[31] ^ add_cout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ctrl_MULT ? MUL_ITER : DIV_ABSA;
        end else begin
            case (state_q)
                MUL_ITER: if (cnt_q == LAST) state_d = DONE;
                DIV_ABSA: state_d = DIV_ABSB;
                DIV_ABSB: state_d = DIV_ITER;
                DIV_ITER: if (cnt_q == LAST) state_d = DIV_SIGN;
                DIV_SIGN: state_d = DONE;
                DONE:     state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        add_x   = 32'b0;
        add_y   = 32'b0;
        add_cin = 1'b0;
        case (state_q)
            MUL_ITER: begin
                add_x   = acc_q;
                add_y   = booth_sub ? ~b_q : (booth_add ? b_q : 32'b0);
                add_cin = booth_sub;
            end
            DIV_ABSA: begin
                add_x   = lo_q[31] ? ~lo_q : lo_q;
                add_cin = lo_q[31];
            end
            DIV_ABSB: begin
                add_x   = b_q[31] ? ~b_q : b_q;
                add_cin = b_q[31];
            end
            DIV_ITER: begin
                add_x   = rem_sh;
                add_y   = ~b_q;
                add_cin = 1'b1;
            end
            DIV_SIGN: begin
                add_x   = neg_q ? ~lo_q : lo_q;
                add_cin = neg_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q    <= 32'b0;
            lo_q     <= 32'b0;
            b_q      <= 32'b0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            mul_q    <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= 32'b0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else if (start) begin
            acc_q <= 32'b0;
            lo_q  <= data_operandA;
            b_q   <= data_operandB;
            qm1_q <= 1'b0;
            cnt_q <= '0;
            mul_q <= ctrl_MULT;
            neg_q <= data_operandA[31] ^ data_operandB[31];
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                MUL_ITER: begin
                    acc_q <= {add_ext, add_s[31:1]};
                    lo_q  <= {add_s[0], lo_q[31:1]};
                    qm1_q <= lo_q[0];
                    cnt_q <= cnt_q + CW'(1);
                end
                DIV_ABSA: lo_q <= add_s;
                DIV_ABSB: b_q  <= add_s;
                DIV_ITER: begin
                    acc_q <= add_cout ? add_s : rem_sh;
                    lo_q  <= {lo_q[30:0], add_cout};
                    cnt_q <= cnt_q + CW'(1);
                end
                DIV_SIGN: lo_q <= add_s;
                DONE: begin
                    rdy_q <= 1'b1;
                    if (mul_q) begin
                        result_q <= lo_q;
                        exc_q    <= (acc_q != {32{lo_q[31]}});
                    end else if (b_q == 32'b0) begin
                        result_q <= 32'b0;
                        exc_q    <= 1'b1;
                    end else begin
                        // A non-negative quotient with bit 31 set did not fit.
                        result_q <= lo_q;
                        exc_q    <= ~neg_q & lo_q[31];
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Multicycle signed multiply/divide sequencer for the processor's execute stage. It time-shares one `adder_32` instance for every 32-bit add and subtract in both operations. Multiply uses radix-2 Booth; divide uses restoring division on magnitudes. The block produces a one-cycle `data_resultRDY` pulse that the pipeline stall logic waits on.

## Interface

Parameters:
- `ITER`, default 32: iteration count (operand width); fixed at 32 for this design.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `ctrl_MULT`  in  1  one-cycle start pulse for multiply A*B.
- `ctrl_DIV`  in  1  one-cycle start pulse for divide A/B.
- `data_operandA`  in  32  signed operand A; sampled only on a start edge.
- `data_operandB`  in  32  signed operand B; sampled only on a start edge.
- `data_result`  out  32  signed result, registered; holds its value until the next result.
- `data_exception`  out  32→1  1 = overflow or divide-by-zero; registered, updated with `data_result`.
- `data_resultRDY`  out  1  high for exactly one cycle when `data_result` and `data_exception` are valid.

Internal datapath:
- A single `adder_32` instance, port order (S, O, A, B, Cin).
- Subtraction is done as A + ~B with Cin=1.
- No other 32-bit adder is permitted.

## Operation

States: IDLE, MUL_ITER, DIV_ABSA, DIV_ABSB, DIV_ITER, DIV_SIGN, DONE.

Start:
- A start is a rising edge with `ctrl_MULT` or `ctrl_DIV` high, in any state.
- It latches both operands, clears the iteration counter, and enters MUL_ITER or DIV_ABSA.
- If both controls are high together, `ctrl_MULT` wins.
- A start in a non-IDLE state aborts the current operation. No `data_resultRDY` pulse is produced for the aborted operation.

Multiply (MUL_ITER, 32 cycles):
- Registers: 65-bit {P_hi, P_lo, q-1}, with P_lo = A and P_hi = 0 at start.
- Each cycle examines {P_lo[0], q-1}:
  - 01: P_hi + B.
  - 10: P_hi − B.
  - 00 or 11: no add.
- After the add, arithmetic-shift the 65-bit register right by 1.
- Result = P_lo.
- Exception = 1 when P_hi ≠ 32 copies of P_lo[31] (the 64-bit product does not fit in 32 bits).

Divide:
- DIV_ABSA: |A| via the adder (~A + 1 when A[31]=1; otherwise pass through).
- DIV_ABSB: |B| computed the same way.
- DIV_ITER, 32 cycles, restoring division:
  - Shift {R, Q} left by 1.
  - Compute trial = R − |B|.
  - If the adder result is non-negative (carry out = 1), set R = trial and Q[0] = 1.
- DIV_SIGN: if A[31]^B[31], result = −Q via the adder; otherwise result = Q.
- Quotient truncates toward zero; the remainder is discarded.
- Divide-by-zero (B = 0): result 0, exception 1, at the normal divide latency.
- 0x80000000 / −1: result 0x80000000, exception 1.

DONE:
- Registers `data_result` and `data_exception`.
- Asserts `data_resultRDY` for one cycle, then returns to IDLE.

## Timing

Reset:
- `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, state = IDLE.
- Takes effect asynchronously.
- Reset mid-operation abandons the operation; no ready pulse follows.

Cycle numbering (E0 = start edge):
- Multiply: iterations on E1–E32; result registered and `data_resultRDY` = 1 after E33; RDY deasserted after E34. Latency 33 cycles.
- Divide: abs(A) on E1, abs(B) on E2, iterations on E3–E34, sign fix on E35; `data_resultRDY` = 1 after E36. Latency 36 cycles.

Other rules:
- Operand inputs may change freely after E0 without affecting the result.
- A start on the same edge that RDY deasserts (back-to-back) is legal. The new operation's timeline begins at that edge.
- `data_resultRDY` is never high for two consecutive cycles.
- The adder's O output is unused for multiply and divide. Overflow detection uses the rules above.

## Test plan

- Multiply 7 × −3 (0xFFFFFFFD) → `data_result` = 0xFFFFFFEB, exception 0, RDY exactly 33 cycles after start and high for 1 cycle.
- Multiply 0x00010000 × 0x00010000 → result 0x00000000, exception 1; 0x7FFFFFFF × 1 → 0x7FFFFFFF, exception 0.
- Divide −7 / 2 → 0xFFFFFFFD (−3), exception 0, RDY 36 cycles after start; 100 / −7 → −14.
- Divide 5 / 0 → result 0, exception 1 at cycle 36; 0x80000000 / 0xFFFFFFFF → 0x80000000, exception 1.
- Start a multiply, then pulse `ctrl_DIV` (operands 9, 3) on cycle 10 → no RDY pulse for the multiply; result 3 with RDY 36 cycles after the `ctrl_DIV` edge. Also, `ctrl_MULT` and `ctrl_DIV` both high with operands 6 and 4 → result 24.
- Assert `reset` at cycle 20 of a divide → all outputs 0 immediately and no RDY pulse. A new multiply 2 × 3 after reset is released → result 6 at cycle 33.
